// File: rtl/issue_pkg.sv
// Shared issue-queue types and sizing for the dequeue scheduler.
// DEPTH follows `ISSUE_QUEUE_DEPTH, falling back to 8 slots when it is not set.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif

package issue_pkg;

  localparam int DEPTH = `ISSUE_QUEUE_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } iq_sched_state_t;

endpackage

// File: rtl/iq_issue_sched_if.sv
// Issue-queue <-> scheduler <-> functional-unit signal bundle.
// The master side is the scheduler; the slave side is the queue/FU.
interface iq_issue_sched_if #(
  parameter int DEPTH = issue_pkg::DEPTH
);
  logic             flush;
  logic             enq_fire;
  logic [DEPTH-1:0] enq_valid_oh;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_ready;
  logic             issue_valid;
  logic [DEPTH-1:0] issue_oh;
  logic             issue_ready;
  logic             issue_fire;
  logic [DEPTH-1:0] deq_ptr_oh;

  modport master (
    input  flush, enq_fire, enq_valid_oh, entry_valid, entry_ready, issue_ready,
    output issue_valid, issue_oh, issue_fire, deq_ptr_oh
  );

  modport slave (
    output flush, enq_fire, enq_valid_oh, entry_valid, entry_ready, issue_ready,
    input  issue_valid, issue_oh, issue_fire, deq_ptr_oh
  );
endinterface

// File: rtl/find_first1_base.sv
// First set bit of vec_i at or after the one-hot base_i, wrapping from the top bit to bit 0.
// Returns zero when vec_i is zero.
module find_first1_base #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [WIDTH-1:0] base_i,
  output logic [WIDTH-1:0] first_o
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] grant;

  // Subtracting the base clears the first request at or above it; the upper copy handles wrap.
  assign dbl     = {vec_i, vec_i};
  assign grant   = dbl & ~(dbl - {{WIDTH{1'b0}}, base_i});
  assign first_o = grant[WIDTH-1:0] | grant[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/iq_age_matrix.sv
// Relative-age matrix over issue-queue slots: age_q[i][j]=1 means slot i is older than slot j.
// Reports the oldest candidate and the oldest valid slot as one-hot vectors.
module iq_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enq_fire_i,
  input  logic [DEPTH-1:0] enq_oh_i,
  input  logic [DEPTH-1:0] entry_valid_i,
  input  logic [DEPTH-1:0] cand_i,
  input  logic [DEPTH-1:0] live_i,
  output logic [DEPTH-1:0] oldest_cand_o,
  output logic [DEPTH-1:0] oldest_live_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  // A new entry is younger than everything currently valid and older than nothing.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
    if (enq_fire_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (enq_oh_i[k]) begin
          for (int j = 0; j < DEPTH; j++) age_d[j][k] = entry_valid_i[j];
          age_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear_i) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    oldest_cand_o = '0;
    oldest_live_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older_cand;
      logic older_live;
      older_cand = 1'b0;
      older_live = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (cand_i[j] && age_q[j][i]) older_cand = 1'b1;
        if (live_i[j] && age_q[j][i]) older_live = 1'b1;
      end
      oldest_cand_o[i] = cand_i[i] & ~older_cand;
      oldest_live_o[i] = live_i[i] & ~older_live;
    end
  end

endmodule

// File: rtl/iq_issue_sched.sv
// Issue-queue dequeue scheduler: picks the oldest ready slot and issues it over a valid/ready handshake.
// `ISSUE_AGE_MATRIX_EN selects true age ordering; otherwise a rotating round-robin pointer orders slots.
module iq_issue_sched #(
  parameter int DEPTH = issue_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  iq_issue_sched_if.master  bus
);
  import issue_pkg::*;

  iq_sched_state_t  state_q;
  logic             issue_valid_q;
  logic [DEPTH-1:0] issue_oh_q;
  logic [DEPTH-1:0] deq_ptr_q;
  logic [DEPTH-1:0] deq_ptr_d;

  logic             fire;
  logic [DEPTH-1:0] fired_oh;
  logic [DEPTH-1:0] enq_oh;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] pick_oh;
  logic [DEPTH-1:0] oldest_live_oh;

  // Reset is folded in so a handshake cut by reset never deallocates its slot.
  assign fire     = issue_valid_q & bus.issue_ready & ~bus.flush & reset_n;
  assign fired_oh = fire ? issue_oh_q : '0;
  assign enq_oh   = bus.enq_fire ? bus.enq_valid_oh : '0;
  assign cand     = bus.entry_valid & bus.entry_ready & ~enq_oh & ~fired_oh;
  assign live     = bus.entry_valid & ~fired_oh;

`ifdef ISSUE_AGE_MATRIX_EN
  iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_i       (bus.flush),
    .enq_fire_i    (bus.enq_fire),
    .enq_oh_i      (bus.enq_valid_oh),
    .entry_valid_i (bus.entry_valid),
    .cand_i        (cand),
    .live_i        (live),
    .oldest_cand_o (pick_oh),
    .oldest_live_o (oldest_live_oh)
  );
`else
  logic [DEPTH-1:0] rr_q;
  logic [DEPTH-1:0] rr_d;

  find_first1_base #(.WIDTH(DEPTH)) u_pick (
    .vec_i   (cand),
    .base_i  (rr_q),
    .first_o (pick_oh)
  );

  find_first1_base #(.WIDTH(DEPTH)) u_deq (
    .vec_i   (live),
    .base_i  (rr_q),
    .first_o (oldest_live_oh)
  );

  // After a fire the slot just past the issued one gets first chance.
  always_comb begin
    rr_d = rr_q;
    if (bus.flush)  rr_d = DEPTH'(1);
    else if (fire)  rr_d = {issue_oh_q[DEPTH-2:0], issue_oh_q[DEPTH-1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) rr_q <= DEPTH'(1);
    else          rr_q <= rr_d;
  end
`endif

  assign deq_ptr_d = (|live) ? oldest_live_oh : deq_ptr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      issue_valid_q <= 1'b0;
      issue_oh_q    <= '0;
      deq_ptr_q     <= DEPTH'(1);
    end else begin
      deq_ptr_q <= deq_ptr_d;
      if (bus.flush) begin
        state_q       <= S_FLUSH;
        issue_valid_q <= 1'b0;
        issue_oh_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (|cand) begin
              state_q       <= S_ISSUE;
              issue_valid_q <= 1'b1;
              issue_oh_q    <= pick_oh;
            end
          end
          S_ISSUE: begin
            // Without a fire the request is frozen, even if an older slot turns ready.
            if (fire) begin
              if (|cand) begin
                issue_oh_q <= pick_oh;
              end else begin
                state_q       <= S_IDLE;
                issue_valid_q <= 1'b0;
                issue_oh_q    <= '0;
              end
            end
          end
          S_FLUSH: begin
            state_q       <= S_IDLE;
            issue_valid_q <= 1'b0;
            issue_oh_q    <= '0;
          end
          default: begin
            state_q       <= S_IDLE;
            issue_valid_q <= 1'b0;
            issue_oh_q    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_oh    = issue_oh_q;
  assign bus.issue_fire  = fire;
  assign bus.deq_ptr_oh  = deq_ptr_q;

endmodule

// File: doc/iq_issue_sched.md
# iq_issue_sched

Issue-queue dequeue scheduler. Each cycle it picks one ready entry, oldest first, from the issue queue's valid/ready vectors. It presents that entry to the functional unit with a valid/ready handshake and clears its issue history on pipeline flush. It sits beside the issue queue's enqueue-pointer policy and supplies the `deq_ptr_oh` that policy aligns to when the queue drains.

## Interface
- `DEPTH`, default `` `ISSUE_QUEUE_DEPTH `` (8): number of issue-queue slots; one-hot vector width.
- `clock` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `flush` in 1: pipeline flush; all queue entries are being invalidated.
- `enq_fire` in 1: an entry is written this cycle.
- `enq_valid_oh` in DEPTH: one-hot slot written this cycle; qualified by `enq_fire`.
- `entry_valid` in DEPTH: per-slot occupied (registered state of the queue).
- `entry_ready` in DEPTH: per-slot operands ready; ignored where `entry_valid`=0.
- `issue_valid` out 1: an issue request is presented.
- `issue_oh` out DEPTH: one-hot slot being issued; 0 when `issue_valid`=0.
- `issue_ready` in 1: FU accepts. `issue_fire` = `issue_valid & issue_ready & ~flush`.
- `issue_fire` out 1: the queue deallocates `issue_oh` at the next edge.
- `deq_ptr_oh` out DEPTH: one-hot slot of the oldest valid entry. Holds its last value when the queue is empty.

## Operation
- Candidates = `entry_valid & entry_ready & ~(enq_fire ? enq_valid_oh : 0) & ~(issue_fire ? issue_oh : 0)`. A newly enqueued slot or a just-fired slot is never a candidate that cycle.
- Pick = oldest candidate (see Configuration). The pick is registered into `issue_oh`.
- FSM, 2-bit state:
  - S_IDLE: if any candidate, load the pick and go to S_ISSUE. Otherwise stay; `issue_valid`=0.
  - S_ISSUE: `issue_valid`=1.
    - If `issue_fire` and a candidate exists: load the new pick and stay in S_ISSUE (back-to-back issue, one per cycle).
    - If `issue_fire` and no candidate exists: go to S_IDLE.
    - If `issue_ready`=0: hold. `issue_oh` must not change while stalled, even if an older entry becomes ready.
  - S_FLUSH: `issue_valid`=0 for exactly one cycle; the age state is already cleared; go to S_IDLE.
- `flush` in any state goes to S_FLUSH. `flush` overrides `issue_ready`: no fire that cycle.
- `deq_ptr_oh` is registered. Each cycle it loads the oldest slot among `entry_valid & ~fired-slot` if that set is non-zero. Otherwise it holds.
- `entry_valid` dropping under a held `issue_oh` without flush is illegal. The bench flags it with an assertion.

## Timing
- Reset (`reset_n`=0 at an edge):
  - state becomes S_IDLE;
  - `issue_valid`=0 and `issue_oh`=0;
  - `deq_ptr_oh`=1 (slot 0);
  - age state and round-robin pointer are cleared.
- Reset mid-handshake drops the request without a fire.
- Latency: a candidate ready at edge N gives `issue_valid` at N+1. Sustained throughput is 1 issue/cycle.
- An entry enqueued already ready at edge N becomes a candidate at N+1 and can issue at N+2.
- Flush asserted at edge N: `issue_valid`=0 from N+1 (S_FLUSH), then S_IDLE at N+2.
- Full queue (all valid, none ready): S_IDLE, no request. Empty queue: `deq_ptr_oh` held.

## Configuration
- `ISSUE_AGE_MATRIX_EN` defined:
  - A DEPTH×DEPTH age matrix is kept; `age[i][j]`=1 means slot i is older than slot j.
  - On enqueue into slot k: `age[j][k]` is set to `entry_valid[j]` for all j, and row k is cleared.
  - Pick = candidate i with no candidate j where `age[j][i]`=1. The same rule over valid entries gives `deq_ptr_oh`.
  - The matrix is cleared on flush or reset.
- `ISSUE_AGE_MATRIX_EN` undefined:
  - Round-robin: pick = first candidate at or after the rotating pointer `rr_oh` (wrapping past slot DEPTH-1 to slot 0).
  - On fire, `rr_oh` moves to `issue_oh` rotated left by 1.
  - `deq_ptr_oh` = first valid at or after `rr_oh`.
  - `rr_oh` resets to 1 and is set to 1 on flush.

## Structure
- Shared package `issue_pkg` holds:
  - the state enum `iq_sched_state_t` {S_IDLE, S_ISSUE, S_FLUSH};
  - the DEPTH localparam, derived from `` `ISSUE_QUEUE_DEPTH ``.
- Sub-module `iq_age_matrix` is instantiated only under `ISSUE_AGE_MATRIX_EN`. It takes the enqueue, clear, candidate and valid vectors and outputs the oldest-candidate and oldest-valid one-hots.
- The round-robin path reuses the existing `find_first1_base`.

## Test plan
- Reset, then slots 2 and 5 valid and ready, with slot 5 enqueued first: `issue_oh`=0x20 one cycle after the vectors settle. Hold `issue_ready`=1; the next cycle gives `issue_oh`=0x04, then S_IDLE.
- Stall: `issue_ready`=0 for 4 cycles with `issue_oh`=0x08 while an older slot 1 becomes ready. `issue_oh` stays 0x08 throughout; release gives `issue_fire`=1, then `issue_oh`=0x02.
- Flush asserted together with `issue_ready`=1: `issue_fire`=0, `issue_valid`=0 for the next 2 cycles, and the age state is cleared. A re-enqueue into slot 7 then issues as the oldest entry.
- Enqueue into slot 3 with `entry_ready` already 1 at edge N: no request at N+1; `issue_oh`=0x08 at N+2.
- Drain all 8 entries: `deq_ptr_oh` follows the oldest valid slot and then holds its value after the queue is empty. Repeat with `ISSUE_AGE_MATRIX_EN` undefined: slots fire in round-robin order wrapping from 7 to 0.
- `reset_n`=0 while `issue_valid`=1: at the next edge `issue_valid`=0, `issue_oh`=0 and `deq_ptr_oh`=0x01, with no `issue_fire`.
